// File: rtl/rv32i_types.sv
// Shared RV32I types: opcode encodings, register index, fetch FSM state
// and the fetch buffer entry layout.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef logic [4:0] rv32i_reg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO of {pc, instr} with a synchronous flush.
// Flush wins over a same-cycle push or pop; pointers and count reset asynchronously.
module fetch_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           wdata_i,
    output fetch_entry_t           rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the consumer masks the head with count != 0.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, issues single-outstanding memory requests,
// buffers returned words and presents the head entry (with sliced fields) to decode.
module fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0060,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    output logic         inst_read,
    output logic [31:0]  inst_addr,
    input  logic         inst_resp,
    input  logic [31:0]  inst_rdata,
    output logic         id_valid,
    input  logic         id_ready,
    output logic [31:0]  id_pc,
    output logic [31:0]  id_instr,
    output rv32i_opcode  id_opcode,
    output logic [2:0]   id_funct3,
    output logic [6:0]   id_funct7,
    output rv32i_reg     id_rs1,
    output rv32i_reg     id_rs2,
    output rv32i_reg     id_rd,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output fetch_state_t dbg_state
);

    // Handshakes: a memory request is live while inst_read is high and retires on the
    // single inst_resp pulse; a decode transfer happens on a cycle with id_valid && id_ready.

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          outstanding_next;
    logic          space;
    fetch_entry_t  head;

    assign push = (state_q == WAIT) && inst_resp && !redirect;
    assign pop  = id_valid && id_ready && !redirect;

    // Occupancy after this cycle, counting a request that is still in flight.
    always_comb begin
        if (redirect) count_next = '0;
        else count_next = buf_count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
    assign outstanding_next = (state_q != FETCH) && !inst_resp;
    assign space = (int'(count_next) + int'(outstanding_next)) < BUF_DEPTH;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            // A request still in flight must be drained before the target can issue.
            if (state_q == FETCH || inst_resp) state_d = WAIT;
            else state_d = DISCARD;
        end else begin
            case (state_q)
                FETCH: begin
                    if (space) state_d = WAIT;
                end
                WAIT: begin
                    if (inst_resp) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = space ? WAIT : FETCH;
                    end
                end
                DISCARD: begin
                    if (inst_resp) state_d = space ? WAIT : FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_comb begin
        inst_read = (state_q != FETCH);
        inst_addr = fetch_pc_q;
        id_valid  = (buf_count != '0);
        id_pc     = id_valid ? head.pc    : 32'h0;
        id_instr  = id_valid ? head.instr : 32'h0;
        id_opcode = rv32i_opcode'(id_instr[6:0]);
        id_funct3 = id_instr[14:12];
        id_funct7 = id_instr[31:25];
        id_rs1    = id_instr[19:15];
        id_rs2    = id_instr[24:20];
        id_rd     = id_instr[11:7];
        dbg_state = state_q;
    end

    fetch_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i ({fetch_pc_q, inst_rdata}),
        .rdata_o (head),
        .count_o (buf_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized phase, with a
// memory responder and a stream-level model of the PCs decode should see.
module tb_fetch_unit;
    import rv32i_types::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0060;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    always #5 clk = ~clk;

    logic         inst_read;
    logic [31:0]  inst_addr;
    logic         inst_resp = 1'b0;
    logic [31:0]  inst_rdata = 32'h0;
    logic         id_valid;
    logic         id_ready = 1'b0;
    logic [31:0]  id_pc, id_instr;
    rv32i_opcode  id_opcode;
    logic [2:0]   id_funct3;
    logic [6:0]   id_funct7;
    rv32i_reg     id_rs1, id_rs2, id_rd;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_pc = 32'h0;
    fetch_state_t dbg_state;

    fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .inst_read(inst_read), .inst_addr(inst_addr),
        .inst_resp(inst_resp), .inst_rdata(inst_rdata),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_funct7(id_funct7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- memory contents and model state ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h60) return 32'h00a00093;
        return (a * 32'h9e3779b1) ^ 32'h1357_9bdf;
    endfunction

    logic [31:0] exp_pc;          // next PC decode must receive
    logic [31:0] exp_q[$];
    logic [31:0] issued[$];       // addresses seen at request start
    logic        mem_busy = 1'b0;
    logic        mem_redir = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] slow_addr = 32'hffff_ffff;
    int          slow_delay = 1;
    int          dly_lo = 1, dly_hi = 1;
    logic        force_junk = 1'b0;
    logic        resp_seen = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc, prev_instr;
    int          n_xfer = 0;

    // ---------------- driver: one clock cycle ----------------
    task automatic step();
        logic [31:0] w;
        if (rst && mem_busy && !mem_redir) begin
            check("req_hold_addr", inst_addr, mem_addr);
            check("req_hold_read", inst_read, 1'b1);
        end
        inst_resp  = 1'b0;
        inst_rdata = 32'h0;
        resp_seen  = 1'b0;
        if (force_junk) begin
            inst_resp  = 1'b1;
            inst_rdata = 32'hdead_beef;
            force_junk = 1'b0;
        end else if (mem_busy) begin
            if (mem_cnt == 0) begin
                inst_resp  = 1'b1;
                inst_rdata = mem_word(mem_addr);
                mem_busy   = 1'b0;
                resp_seen  = 1'b1;
            end else begin
                mem_cnt--;
            end
        end else if (rst && inst_read) begin
            mem_busy  = 1'b1;
            mem_redir = 1'b0;
            mem_addr  = inst_addr;
            issued.push_back(inst_addr);
            if (inst_addr == slow_addr) mem_cnt = slow_delay - 1;
            else mem_cnt = int'($urandom_range(dly_hi, dly_lo)) - 1;
        end
        if (redirect && mem_busy) mem_redir = 1'b1;

        // scoreboard
        if (rst && prev_stall) begin
            check("hold_pc", id_pc, prev_pc);
            check("hold_instr", id_instr, prev_instr);
        end
        if (rst && id_valid && id_ready && !redirect) begin
            w = mem_word(exp_pc);
            check("id_pc", id_pc, exp_pc);
            check("id_instr", id_instr, w);
            check("id_opcode", id_opcode, w[6:0]);
            check("id_funct3", id_funct3, w[14:12]);
            check("id_funct7", id_funct7, w[31:25]);
            check("id_rs1", id_rs1, w[19:15]);
            check("id_rs2", id_rs2, w[24:20]);
            check("id_rd", id_rd, w[11:7]);
            exp_pc += 32'd4;
            n_xfer++;
        end
        prev_stall = rst && id_valid && !id_ready && !redirect;
        prev_pc    = id_pc;
        prev_instr = id_instr;
        if (rst && redirect) exp_pc = redirect_pc & ~32'h3;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
        inst_resp = 1'b0;
        mem_busy = 1'b0;
        force_junk = 1'b0;
        prev_stall = 1'b0;
        exp_pc = RESET_PC;
        slow_addr = 32'hffff_ffff;
        dly_lo = 1;
        dly_hi = 1;
        issued.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        step();
        redirect = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int x0;

        // async reset values
        #1 rst = 1'b0;
        #1;
        check("rst_read", inst_read, 1'b0);
        check("rst_addr", inst_addr, RESET_PC);
        check("rst_valid", id_valid, 1'b0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_opcode", id_opcode, 32'h0);
        check("rst_state", dbg_state, FETCH);

        // sequential fetch with 1-cycle memory
        do_reset();
        id_ready = 1'b1;
        step();
        check("first_read", inst_read, 1'b1);
        check("first_addr", inst_addr, RESET_PC);
        k = 0;
        while (!resp_seen && k < 20) begin step(); k++; end
        check("tmo_first_resp", k < 20, 1'b1);
        check("resp_to_valid", id_valid, 1'b1);
        check("dec_pc", id_pc, 32'h60);
        check("dec_opcode", id_opcode, op_imm);
        check("dec_rd", id_rd, 5'd1);
        check("dec_rs1", id_rs1, 5'd0);
        check("dec_funct3", id_funct3, 3'd0);
        check("next_addr", inst_addr, 32'h64);
        check("next_read", inst_read, 1'b1);
        run(10);
        exp_q = {32'h60, 32'h64, 32'h68};
        check("issue_cnt", issued.size() >= 3, 1'b1);
        for (int i = 0; i < 3 && i < issued.size(); i++) check("issue_seq", issued[i], exp_q[i]);

        // decode stall fills the buffer, then drains in order
        do_reset();
        run(10);
        check("stall_read", inst_read, 1'b0);
        check("stall_issued", issued.size(), 2);
        check("stall_valid", id_valid, 1'b1);
        check("stall_head", id_pc, 32'h60);
        check("stall_state", dbg_state, FETCH);
        id_ready = 1'b1;
        x0 = n_xfer;
        run(3);
        check("drain_cnt", n_xfer - x0, 2);

        // redirect while a slow request is outstanding
        do_reset();
        id_ready = 1'b1;
        slow_addr = 32'h68;
        slow_delay = 4;
        k = 0;
        while (!(mem_busy && mem_addr == 32'h68) && k < 30) begin step(); k++; end
        check("tmo_req68", k < 30, 1'b1);
        do_redirect(32'h200);
        check("redir_valid", id_valid, 1'b0);
        check("redir_state", dbg_state, DISCARD);
        k = 0;
        while (!resp_seen && k < 10) begin step(); k++; end
        check("tmo_discard_resp", k < 10, 1'b1);
        check("redir_addr", inst_addr, 32'h200);
        check("redir_read", inst_read, 1'b1);
        run(6);
        check("redir_seen", exp_pc >= 32'h204, 1'b1);

        // redirect and response in the same cycle, buffer full
        do_reset();
        slow_addr = 32'h64;
        slow_delay = 3;
        k = 0;
        while (!(mem_busy && mem_addr == 32'h64 && mem_cnt == 0) && k < 30) begin step(); k++; end
        check("tmo_req64", k < 30, 1'b1);
        check("full_valid", id_valid, 1'b1);
        id_ready = 1'b1;
        do_redirect(32'h400);
        check("same_resp", resp_seen, 1'b1);
        check("same_valid", id_valid, 1'b0);
        check("same_addr", inst_addr, 32'h400);
        check("same_state", dbg_state, WAIT);
        run(6);
        check("same_seen", exp_pc >= 32'h404, 1'b1);

        // unaligned redirect target issued from FETCH
        id_ready = 1'b0;
        run(12);
        check("idle_read", inst_read, 1'b0);
        issued.delete();
        do_redirect(32'h303);
        check("align_addr", inst_addr, 32'h300);
        check("align_read", inst_read, 1'b1);
        check("align_valid", id_valid, 1'b0);
        id_ready = 1'b1;
        run(6);
        check("align_issue", issued.size() >= 1 ? issued[0] : 32'hx, 32'h300);

        // PC wrap-around
        id_ready = 1'b0;
        run(12);
        issued.delete();
        do_redirect(32'hffff_fffc);
        id_ready = 1'b1;
        k = 0;
        while (!resp_seen && k < 10) begin step(); k++; end
        check("tmo_wrap_resp", k < 10, 1'b1);
        check("wrap_addr", inst_addr, 32'h0);
        run(6);
        check("wrap_issued", issued.size() >= 2, 1'b1);
        if (issued.size() >= 2) check("wrap_issue1", issued[1], 32'h0);

        // reset mid-WAIT, then a stray response while in FETCH
        do_reset();
        id_ready = 1'b1;
        k = 0;
        while (!(dbg_state == WAIT && mem_busy) && k < 20) begin step(); k++; end
        check("tmo_midwait", k < 20, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_read", inst_read, 1'b0);
        check("mid_rst_addr", inst_addr, RESET_PC);
        check("mid_rst_valid", id_valid, 1'b0);
        check("mid_rst_pc", id_pc, 32'h0);
        check("mid_rst_state", dbg_state, FETCH);
        mem_busy = 1'b0;
        prev_stall = 1'b0;
        exp_pc = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        force_junk = 1'b1;
        step();
        check("junk_valid", id_valid, 1'b0);
        check("junk_read", inst_read, 1'b1);
        check("junk_addr", inst_addr, RESET_PC);
        x0 = n_xfer;
        run(10);
        check("restart_xfer", n_xfer > x0, 1'b1);

        // randomized traffic
        do_reset();
        dly_lo = 1;
        dly_hi = 3;
        x0 = n_xfer;
        for (int i = 0; i < 2000; i++) begin
            id_ready = ($urandom_range(9, 0) < 7);
            redirect = ($urandom_range(19, 0) == 0);
            if ($urandom_range(3, 0) == 0) redirect_pc = 32'hffff_fff0 + $urandom_range(15, 0);
            else redirect_pc = $urandom;
            step();
        end
        redirect = 1'b0;
        check("rand_progress", (n_xfer - x0) > 50, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
